// File: rtl/rot_pkg.sv
// rot_pkg: FSM state encoding and default sizing shared by the rotating-tile loader
package rot_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;
  localparam int DEF_NTILES = 64;
  localparam int DEF_CFG_W  = 2;
  localparam int DEF_IN_W   = 2;
endpackage

// File: rtl/rot_shreg.sv
// rot_shreg: TOTAL-bit register that shifts in IN_W bits at the LSBs or rotates left by one
module rot_shreg #(
  parameter int TOTAL = 128,
  parameter int IN_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sh,
  input  logic             rot,
  input  logic [IN_W-1:0]  din,
  output logic [TOTAL-1:0] sr_q
);
  logic [TOTAL-1:0] sr_d;
  // Shift has priority; rotate moves the MSB around to the LSB for serial readback
  always_comb
    sr_d = sh ? TOTAL'({sr_q, din}) : rot ? ((sr_q << 1) | (sr_q >> (TOTAL - 1))) : sr_q;
  // Register with synchronous active-low clear
  always_ff @(posedge clk)
    if (!rst_n) sr_q <= '0;
    else sr_q <= sr_d;
endmodule

// File: rtl/rot_cfg_loader.sv
// rot_cfg_loader: beat-serial configuration loader with atomic commit and rotating readback
module rot_cfg_loader
  import rot_pkg::*;
#(
  parameter int NTILES = DEF_NTILES,
  parameter int CFG_W  = DEF_CFG_W,
  parameter int IN_W   = DEF_IN_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      in_valid,
  input  logic [IN_W-1:0]           in_data,
  output logic                      in_ready,
  input  logic                      rd_en,
  output logic [NTILES*CFG_W-1:0]   cfg_out,
  output logic                      sc_out,
  output logic                      busy,
  output logic                      done
);
  localparam int TOTAL = NTILES * CFG_W;
  localparam int BEATS = TOTAL / IN_W;
  localparam int CW    = $clog2(BEATS + 1);
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TOTAL-1:0] cfg_q, cfg_d, sr_q;
  logic             done_q, done_d, sh, rot, commit;
  rot_shreg #(.TOTAL(TOTAL), .IN_W(IN_W)) u_shreg (
    .clk  (clk),
    .rst_n(rst_n),
    .sh   (sh),
    .rot  (rot),
    .din  (in_data),
    .sr_q (sr_q)
  );
  // Next state, beat counter and shift/rotate strobes; abort beats start beats data
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh      = 1'b0;
    rot     = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else if (rd_en) state_d = READ;
      end
      LOAD: begin
        if (abort) state_d = IDLE;
        else if (start) cnt_d = '0;
        else if (in_valid) begin
          sh = 1'b1;
          if (cnt_q == CW'(BEATS - 1)) begin
            commit  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 1'b1;
        end
      end
      READ: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else if (rd_en) rot = 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // The grid sees the finished image only, taken from the final shift on the same edge
  always_comb begin
    cfg_d  = commit ? TOTAL'({sr_q, in_data}) : cfg_q;
    done_d = commit;
  end
  // State, counter, committed image and done pulse registers
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cfg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
    end
  assign busy     = (state_q == LOAD);
  assign in_ready = busy;
  assign cfg_out  = cfg_q;
  assign done     = done_q;
  assign sc_out   = sr_q[TOTAL-1];
endmodule

// File: tb/tb_rot_cfg_loader.sv
// tb_rot_cfg_loader: scoreboard bench for the default and a 4-tile loader
module tb_rot_cfg_loader;
  logic clk = 1'b0, rst_n;
  logic b_start, b_abort, b_iv, b_rd, b_rdy, b_sc, b_busy, b_done;
  logic [1:0] b_id;
  logic [127:0] b_cfg;
  logic s_start, s_abort, s_iv, s_rd, s_rdy, s_sc, s_busy, s_done;
  logic [1:0] s_id;
  logic [7:0] s_cfg;
  int ntests = 0, nfail = 0, bbusy = 0, bdone = 0, m_cnt = 0;
  bit m_load = 0;
  logic [127:0] m_sr = '0, prev;
  logic [127:0] sbq[$];
  always #5 clk = ~clk;
  rot_cfg_loader u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .in_valid(b_iv),
    .in_data(b_id), .in_ready(b_rdy), .rd_en(b_rd), .cfg_out(b_cfg), .sc_out(b_sc),
    .busy(b_busy), .done(b_done)
  );
  rot_cfg_loader #(.NTILES(4), .CFG_W(2), .IN_W(2)) u_sml (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .in_valid(s_iv),
    .in_data(s_id), .in_ready(s_rdy), .rd_en(s_rd), .cfg_out(s_cfg), .sc_out(s_sc),
    .busy(s_busy), .done(s_done)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic bcyc(input bit st, input bit ab, input bit v, input logic [1:0] d);
    b_start = st;
    b_abort = ab;
    b_iv    = v;
    b_id    = d;
    if (m_load) begin
      if (ab) m_load = 0;
      else if (st) m_cnt = 0;
      else if (v) begin
        m_sr = {m_sr[125:0], d};
        m_cnt++;
        if (m_cnt == 64) begin
          sbq.push_back(m_sr);
          m_load = 0;
          m_cnt  = 0;
        end
      end
    end else if (st) begin
      m_load = 1;
      m_cnt  = 0;
    end
    tick;
    b_start = 0;
    b_abort = 0;
    b_iv    = 0;
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (b_busy) bbusy++;
      if (b_done) begin
        bdone++;
        if (sbq.size() != 0) chk("cfg_commit", b_cfg, sbq.pop_front());
        else chk("spurious_done", 128'(b_done), 128'(0));
      end
    end
  initial begin
    logic [7:0] e;
    logic [1:0] sb[4];
    int d0, guard;
    rst_n = 0;
    {b_start, b_abort, b_iv, b_rd, b_id} = '0;
    {s_start, s_abort, s_iv, s_rd, s_id} = '0;
    repeat (2) tick;
    chk("rst_busy", 128'(b_busy), 0);
    chk("rst_ready", 128'(b_rdy), 0);
    chk("rst_sc", 128'(b_sc), 0);
    chk("rst_cfg", b_cfg, 0);
    chk("rst_done", 128'(b_done), 0);
    chk("rst_scfg", 128'(s_cfg), 0);
    rst_n = 1;
    tick;
    s_start = 1;
    tick;
    s_start = 0;
    sb = '{2'b11, 2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      s_iv = 1;
      s_id = sb[i];
      tick;
    end
    s_iv = 0;
    chk("s_done_hi", 128'(s_done), 1);
    chk("s_cfg_e4", 128'(s_cfg), 128'(8'he4));
    chk("s_busy_lo", 128'(s_busy), 0);
    tick;
    chk("s_done_lo", 128'(s_done), 0);
    e = 8'he4;
    s_rd = 1;
    tick;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("s_sc%0d", i), 128'(s_sc), 128'(e[7]));
      tick;
      e = {e[6:0], e[7]};
    end
    s_rd = 0;
    tick;
    chk("s_restored", 128'(e), 128'(8'he4));
    chk("s_sc_idle", 128'(s_sc), 1);
    s_rd = 1;
    tick;
    chk("s_rdy_read", 128'(s_rdy), 0);
    s_start = 1;
    tick;
    s_start = 0;
    chk("s_busy_start_rd", 128'(s_busy), 1);
    sb = '{2'b00, 2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 4; i++) begin
      s_iv = 1;
      s_id = sb[i];
      s_rd = (i < 3);
      tick;
    end
    s_iv = 0;
    chk("s_cfg_1b", 128'(s_cfg), 128'(8'h1b));
    bbusy = 0;
    bcyc(1, 0, 0, 0);
    repeat (64) bcyc(0, 0, 1, 2'b01);
    tick;
    tick;
    chk("l64_done", 128'(bdone), 1);
    chk("l64_busy", 128'(bbusy), 64);
    chk("l64_cfg", b_cfg, {64{2'b01}});
    d0 = bdone;
    prev = b_cfg;
    bcyc(1, 0, 0, 0);
    repeat (10) bcyc(0, 0, 1, 2'($urandom));
    bcyc(0, 1, 1, 2'b11);
    chk("abort_rdy", 128'(b_rdy), 0);
    chk("abort_busy", 128'(b_busy), 0);
    tick;
    chk("abort_cfg", b_cfg, prev);
    chk("abort_nodone", 128'(bdone), 128'(d0));
    bcyc(1, 0, 0, 0);
    repeat (30) bcyc(0, 0, 1, 2'($urandom));
    bcyc(1, 0, 1, 2'b01);
    chk("restart_cfg", b_cfg, prev);
    repeat (64) bcyc(0, 0, 1, 2'b10);
    tick;
    tick;
    chk("restart_done", 128'(bdone), 128'(d0 + 1));
    chk("restart_cfg2", b_cfg, {64{2'b10}});
    bcyc(1, 0, 0, 0);
    guard = 0;
    while (m_load && guard < 1000) begin
      bcyc(0, 0, 1'($urandom_range(0, 1)), 2'($urandom));
      guard++;
    end
    chk("rand_guard", 128'(m_load), 0);
    tick;
    tick;
    chk("rand_cfg", b_cfg, m_sr);
    d0 = bdone;
    prev = b_cfg;
    repeat (20) bcyc(0, 0, 1'($urandom_range(0, 1)), 2'($urandom));
    chk("idle_cfg", b_cfg, prev);
    chk("idle_busy", 128'(b_busy), 0);
    chk("idle_done", 128'(bdone), 128'(d0));
    bcyc(1, 0, 0, 0);
    repeat (39) bcyc(0, 0, 1, 2'($urandom));
    b_iv = 1;
    rst_n = 0;
    tick;
    rst_n = 1;
    b_iv = 0;
    m_load = 0;
    m_cnt = 0;
    m_sr = '0;
    chk("mrst_busy", 128'(b_busy), 0);
    chk("mrst_rdy", 128'(b_rdy), 0);
    chk("mrst_sc", 128'(b_sc), 0);
    chk("mrst_done", 128'(b_done), 0);
    chk("mrst_cfg", b_cfg, 0);
    repeat (3) tick;
    chk("mrst_nodone", 128'(bdone), 128'(d0));
    chk("sb_empty", 128'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
